vga_disp_pipe: RTL

- Parametrised VGA display engine: timing generator, pixel-address generator and latency-matched output pipeline in one block.
- Fetches pixels from an external video memory with configurable read latency, and delays sync/blank to stay aligned with returned data.
- Accepts RGB888 or RGB565 memory formats.
- Sits between the video memory and the VGA pins; the VGA pin clock is driven from clk outside this block.

---
 rtl/vga_disp_pipe.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_disp_pipe.sv
// -----------------------------------------------------------------------------
// vga_disp_pipe
//
// VGA display engine: raster timing generator, pixel-address generator and a
// latency-matched output pipeline. Pixel requests (h_addr/v_addr/rd_en) go out
// combinationally from the counter stage. Timing and control flags travel
// through an RD_LAT-deep shift chain so they meet the returned rd_data at the
// output register. Every VGA-side output is registered.
//
// Total latency from a counter position to its VGA output is RD_LAT+1 clocks:
// RD_LAT clocks of memory latency plus the output register.
//
// Optional build macro:
//   VGA_TEST_PATTERN_EN - adds input pat_sel. When pat_sel=1 the colour output
//                         becomes 8 vertical colour bars and rd_en is held low.
//
// Ports:
//   clk          in   pixel clock (sole clock)
//   rst          in   synchronous active-high reset
//   en           in   display enable; 0 holds counters at 0 and blanks output
//   pat_sel      in   (VGA_TEST_PATTERN_EN only) colour-bar select
//   h_addr       out  [ADDR_W] column being requested (0 outside active)
//   v_addr       out  [ADDR_W] row being requested (0 outside active)
//   rd_en        out  pixel request strobe
//   rd_data      in   [PIX_W] pixel data, valid RD_LAT clocks after rd_en
//   hsync/vsync  out  sync outputs, polarity set by SYNC_POL
//   valid        out  active-video flag (blank_n)
//   vga_r/g/b    out  [8] colour, 0 when valid=0
//   frame_start  out  pulse on the first active pixel of a frame
//   line_start   out  pulse on the first active pixel of each active line
//
// RD_LAT legal range is 1..4. PIX_W must be 24 for PIX_MODE=0 (RGB888) and
// 16 for PIX_MODE=1 (RGB565).
// -----------------------------------------------------------------------------
module vga_disp_pipe #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int RD_LAT   = 1,
    parameter int PIX_MODE = 0,
    parameter int ADDR_W   = 10,
    parameter int PIX_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              pat_sel,
`endif
    output logic [ADDR_W-1:0] h_addr,
    output logic [ADDR_W-1:0] v_addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start,
    output logic              line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Deasserted sync level: high for active-low sync, low for active-high.
    localparam logic SYNC_OFF = (SYNC_POL == 0);

    // Control word carried through the latency chain.
    localparam int C_ACT = 0;
    localparam int C_HS  = 1;
    localparam int C_VS  = 2;
    localparam int C_FS  = 3;
    localparam int C_LS  = 4;
`ifdef VGA_TEST_PATTERN_EN
    localparam int C_PAT = 5;
    localparam int C_BAR = 6;
    localparam int CTL_W = 9;
`else
    localparam int CTL_W = 5;
`endif

    genvar gi;

    // -------------------------------------------------------------------------
    // Raster counters
    // -------------------------------------------------------------------------
    logic [HC_W-1:0] h_cnt_q, h_cnt_d;
    logic [VC_W-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]     h_pos, v_pos;

    // Zero-extended copies so every comparison against the integer geometry
    // parameters is done at a common 32-bit width.
    assign h_pos = 32'(h_cnt_q);
    assign v_pos = 32'(v_cnt_q);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_pos == H_TOTAL - 1) begin
            h_cnt_d = '0;
            if (v_pos == V_TOTAL - 1) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VC_W'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional colour-bar index, tracked incrementally alongside h_cnt so no
    // divider is needed. It restarts whenever h_cnt is about to be 0.
    // -------------------------------------------------------------------------
    logic pat_on;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BW_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [BW_W-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]      bar_idx_q, bar_idx_d;

    always_comb begin
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (h_cnt_d == '0) begin
            bar_pos_d = '0;
            bar_idx_d = '0;
        end else if (32'(bar_pos_q) == BAR_W - 1) begin
            bar_pos_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_pos_d = bar_pos_q + BW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_pos_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign pat_on = pat_sel;
`else
    assign pat_on = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Stage 0: request generation and raw timing flags
    // -------------------------------------------------------------------------
    logic act, hs_raw, vs_raw, fs_raw, ls_raw;

    assign act    = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign hs_raw = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
    assign vs_raw = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
    assign ls_raw = act && (h_pos == 0);
    assign fs_raw = ls_raw && (v_pos == 0);

    // rst is included so no request leaves the block while reset is held,
    // even though the counters only clear on the following edge.
    assign rd_en  = act & en & ~rst & ~pat_on;
    assign h_addr = act ? ADDR_W'(h_cnt_q) : '0;
    assign v_addr = act ? ADDR_W'(v_cnt_q) : '0;

    logic [CTL_W-1:0] ctl_s0;

    // With en low the chain is fed inactive values so the output drains.
    always_comb begin
        ctl_s0        = '0;
        ctl_s0[C_ACT] = act    & en;
        ctl_s0[C_HS]  = hs_raw & en;
        ctl_s0[C_VS]  = vs_raw & en;
        ctl_s0[C_FS]  = fs_raw & en;
        ctl_s0[C_LS]  = ls_raw & en;
`ifdef VGA_TEST_PATTERN_EN
        ctl_s0[C_PAT]       = pat_sel & en;
        ctl_s0[C_BAR +: 3]  = bar_idx_q;
`endif
    end

    // -------------------------------------------------------------------------
    // Latency-matching chain: RD_LAT registers, so the control word for a
    // request leaves the chain on the same clock its rd_data arrives.
    // -------------------------------------------------------------------------
    logic [RD_LAT:0][CTL_W-1:0] ctl_chain;

    assign ctl_chain[0] = ctl_s0;

    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            logic [CTL_W-1:0] stage_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= ctl_chain[gi];
                end
            end

            assign ctl_chain[gi+1] = stage_q;
        end
    endgenerate

    logic [CTL_W-1:0] ctl_dly;
    assign ctl_dly = ctl_chain[RD_LAT];

    // -------------------------------------------------------------------------
    // Pixel format decode
    // -------------------------------------------------------------------------
    logic [7:0] pix_r, pix_g, pix_b;

    generate
        if (PIX_MODE == 0) begin : g_rgb888
            assign pix_r = rd_data[23:16];
            assign pix_g = rd_data[15:8];
            assign pix_b = rd_data[7:0];
        end else begin : g_rgb565
            // Replicate the top bits into the low bits so full-scale 5/6-bit
            // values map to 8'hFF and zero stays zero.
            assign pix_r = {rd_data[15:11], rd_data[15:13]};
            assign pix_g = {rd_data[10:5],  rd_data[10:9]};
            assign pix_b = {rd_data[4:0],   rd_data[4:2]};
        end
    endgenerate

    logic [7:0] col_r, col_g, col_b;

    always_comb begin
        col_r = pix_r;
        col_g = pix_g;
        col_b = pix_b;
`ifdef VGA_TEST_PATTERN_EN
        if (ctl_dly[C_PAT]) begin
            col_r = {8{ctl_dly[C_BAR+2]}};
            col_g = {8{ctl_dly[C_BAR+1]}};
            col_b = {8{ctl_dly[C_BAR]}};
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Output register. Gating with en as well as feeding the chain with
    // inactive values lets the pins go blank one clock after en falls instead
    // of waiting for the whole chain to empty.
    // -------------------------------------------------------------------------
    logic       show;
    logic       valid_q, hsync_q, vsync_q, fs_q, ls_q;
    logic [7:0] r_q, g_q, b_q;

    assign show = ctl_dly[C_ACT] & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            hsync_q <= SYNC_OFF;
            vsync_q <= SYNC_OFF;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= show;
            hsync_q <= (ctl_dly[C_HS] & en) ^ SYNC_OFF;
            vsync_q <= (ctl_dly[C_VS] & en) ^ SYNC_OFF;
            fs_q    <= ctl_dly[C_FS] & en;
            ls_q    <= ctl_dly[C_LS] & en;
            // rd_data is only looked at while the delayed active flag is set.
            if (show) begin
                r_q <= col_r;
                g_q <= col_g;
                b_q <= col_b;
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule
